// File: rtl/modn_wrap_pwm_pkg.sv
// modn_wrap_pwm_pkg: state encoding and period saturation helper shared by
// the wrap detector and the PWM/period top level.
package modn_wrap_pwm_pkg;

    typedef enum logic [1:0] {INIT, SYNC, ARMED, LOCKED} state_t;

    function automatic int unsigned period_sat(input int unsigned w);
        return (32'd1 << (w + 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/modn_wrap_detect.sv
// modn_wrap_detect: tracks the previous count, flags a wrap when the count
// drops, sequences INIT/SYNC/ARMED/LOCKED and registers the wrap pulse.
module modn_wrap_detect
    import modn_wrap_pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_wrap,
    output logic             o_wrap_pulse,
    output state_t           o_state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt_d;
    logic             r_pulse;
    logic             w_wrap;

    // A stalled upstream (equal count) never counts as a wrap.
    assign w_wrap       = i_en && (r_state != INIT) && (i_cnt < r_cnt_d);
    assign o_wrap       = w_wrap;
    assign o_wrap_pulse = r_pulse;
    assign o_state      = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_cnt_d <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pulse <= w_wrap;
            if (i_en)
                r_cnt_d <= i_cnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_en) begin
            case (r_state)
                INIT:    w_state_nxt = SYNC;
                SYNC:    w_state_nxt = w_wrap ? ARMED : SYNC;
                ARMED:   w_state_nxt = w_wrap ? LOCKED : ARMED;
                default: w_state_nxt = LOCKED;
            endcase
        end
    end

endmodule

// File: rtl/modn_wrap_pwm.sv
// modn_wrap_pwm: wrap event counter, period measurement and glitch-free
// double-buffered PWM. MODN_WRAP_PWM_STICKY_IRQ_EN adds a sticky wrap irq.
module modn_wrap_pwm
    import modn_wrap_pwm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EVW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_cnt_in,
    input  logic [WIDTH-1:0] i_duty_in,
    input  logic             i_duty_wr,
`ifdef MODN_WRAP_PWM_STICKY_IRQ_EN
    input  logic             i_irq_clr,
    output logic             o_irq,
`endif
    output logic             o_pwm_out,
    output logic             o_wrap_pulse,
    output logic [EVW-1:0]   o_wraps,
    output logic [WIDTH:0]   o_period,
    output logic             o_period_valid
);

    localparam logic [WIDTH:0] P_MAX = (WIDTH+1)'(period_sat(WIDTH));

    logic             w_wrap;
    state_t           w_state;
    logic [WIDTH-1:0] w_active_nxt;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_vld;
    logic [WIDTH-1:0] r_active;
    logic             r_pwm;
    logic [EVW-1:0]   r_wraps;
    logic [WIDTH:0]   r_pcnt;
    logic [WIDTH:0]   r_period;
    logic             r_pvalid;

    modn_wrap_detect #(.WIDTH(WIDTH)) u_detect (
        .clk          (clk),
        .rst          (rst),
        .i_en         (i_en),
        .i_cnt        (i_cnt_in),
        .o_wrap       (w_wrap),
        .o_wrap_pulse (o_wrap_pulse),
        .o_state      (w_state)
    );

    // A write landing on the wrap sample bypasses the pending register.
    assign w_active_nxt = (w_wrap && i_duty_wr)  ? i_duty_in :
                          (w_wrap && r_pend_vld) ? r_pend    : r_active;

    assign o_pwm_out      = r_pwm;
    assign o_wraps        = r_wraps;
    assign o_period       = r_period;
    assign o_period_valid = r_pvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_active   <= '0;
        end else begin
            r_active <= w_active_nxt;
            if (i_duty_wr && !w_wrap) begin
                r_pend     <= i_duty_in;
                r_pend_vld <= 1'b1;
            end else if (w_wrap) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // Compare against the post-swap duty so a new period starts on its new threshold.
    always_ff @(posedge clk) begin
        if (rst)
            r_pwm <= 1'b0;
        else if (i_en)
            r_pwm <= i_cnt_in < w_active_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_wraps <= '0;
        else if (w_wrap)
            r_wraps <= r_wraps + EVW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt   <= '0;
            r_period <= '0;
            r_pvalid <= 1'b0;
        end else if (i_en) begin
            if (w_wrap) begin
                r_pcnt <= (WIDTH+1)'(1);
                if (w_state != SYNC) begin
                    r_period <= r_pcnt;
                    r_pvalid <= 1'b1;
                end
            end else if (r_pcnt != P_MAX) begin
                r_pcnt <= r_pcnt + (WIDTH+1)'(1);
            end
        end
    end

`ifdef MODN_WRAP_PWM_STICKY_IRQ_EN
    logic r_irq;

    assign o_irq = r_irq;

    always_ff @(posedge clk) begin
        if (rst)
            r_irq <= 1'b0;
        else if (w_wrap)
            r_irq <= 1'b1;
        else if (i_irq_clr)
            r_irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_modn_wrap_pwm.sv
// tb_modn_wrap_pwm: directed vectors for modn_wrap_pwm at default size and at
// WIDTH=2/EVW=4 for event-counter rollover and period saturation.
module tb_modn_wrap_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] cnt = '0;
    logic [7:0] duty = '0;
    logic       s_en = 1'b0;
    logic [1:0] s_cnt = '0;

    logic        pwm, pulse, pvalid;
    logic [15:0] wraps;
    logic [8:0]  period;
    logic        s_pwm, s_pulse, s_pvalid;
    logic [3:0]  s_wraps;
    logic [2:0]  s_period;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef MODN_WRAP_PWM_STICKY_IRQ_EN
    logic irq_clr = 1'b0;
    logic irq, s_irq;
`endif

    modn_wrap_pwm #(.WIDTH(8), .EVW(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_en           (en),
        .i_cnt_in       (cnt),
        .i_duty_in      (duty),
        .i_duty_wr      (wr),
`ifdef MODN_WRAP_PWM_STICKY_IRQ_EN
        .i_irq_clr      (irq_clr),
        .o_irq          (irq),
`endif
        .o_pwm_out      (pwm),
        .o_wrap_pulse   (pulse),
        .o_wraps        (wraps),
        .o_period       (period),
        .o_period_valid (pvalid)
    );

    modn_wrap_pwm #(.WIDTH(2), .EVW(4)) dut_s (
        .clk            (clk),
        .rst            (rst),
        .i_en           (s_en),
        .i_cnt_in       (s_cnt),
        .i_duty_in      (2'd0),
        .i_duty_wr      (1'b0),
`ifdef MODN_WRAP_PWM_STICKY_IRQ_EN
        .i_irq_clr      (1'b0),
        .o_irq          (s_irq),
`endif
        .o_pwm_out      (s_pwm),
        .o_wrap_pulse   (s_pulse),
        .o_wraps        (s_wraps),
        .o_period       (s_period),
        .o_period_valid (s_pvalid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic feed(input logic [7:0] c);
        cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic feedw(input logic [7:0] c, input logic [7:0] d);
        cnt  = c;
        duty = d;
        wr   = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic sfeed(input logic [1:0] c);
        s_cnt = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_pulse", 32'(pulse), 0);
        chk("rst_wraps", 32'(wraps), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_pvalid", 32'(pvalid), 0);
`ifdef MODN_WRAP_PWM_STICKY_IRQ_EN
        chk("rst_irq", 32'(irq), 0);
`endif
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 5; i++) feed(8'(i));
        chk("sync_no_pulse", 32'(pulse), 0);
        feed(0);
        chk("wrap1_pulse", 32'(pulse), 1);
        chk("wrap1_wraps", 32'(wraps), 1);
        chk("wrap1_pvalid", 32'(pvalid), 0);
        feed(1);
        chk("pulse_one_cycle", 32'(pulse), 0);
        for (int i = 2; i < 5; i++) feed(8'(i));
        feed(0);
        chk("wrap2_pulse", 32'(pulse), 1);
        chk("wrap2_wraps", 32'(wraps), 2);
        chk("wrap2_period", 32'(period), 5);
        chk("wrap2_pvalid", 32'(pvalid), 1);
        chk("duty0_pwm", 32'(pwm), 0);
        feedw(1, 8'd3);
        chk("pend_no_glitch", 32'(pwm), 0);
        for (int i = 2; i < 5; i++) feed(8'(i));
        chk("pend_hold", 32'(pwm), 0);
        feed(0);
        chk("swap_c0", 32'(pwm), 1);
        chk("wrap3_wraps", 32'(wraps), 3);
        for (int c = 1; c < 5; c++) begin
            feed(8'(c));
            chk($sformatf("duty3_c%0d", c), 32'(pwm), (c < 3) ? 1 : 0);
        end
        feedw(0, 8'd2);
        chk("bypass_c0", 32'(pwm), 1);
        chk("wrap4_wraps", 32'(wraps), 4);
        for (int c = 1; c < 5; c++) begin
            feed(8'(c));
            chk($sformatf("duty2_c%0d", c), 32'(pwm), (c < 2) ? 1 : 0);
        end
        feed(0);
        chk("duty2_keep_c0", 32'(pwm), 1);
        chk("wrap5_wraps", 32'(wraps), 5);
        feed(1);
        chk("pre_stall_pwm", 32'(pwm), 1);
        en = 1'b0;
        repeat (3) feed(3);
        chk("stall_pwm_held", 32'(pwm), 1);
        chk("stall_no_pulse", 32'(pulse), 0);
        chk("stall_wraps", 32'(wraps), 5);
        en = 1'b1;
        feed(2);
        chk("resume_pwm", 32'(pwm), 0);
        feed(3);
        feed(4);
        feed(0);
        chk("wrap6_pulse", 32'(pulse), 1);
        chk("wrap6_period", 32'(period), 5);
        feed(1);
        feed(1);
        chk("equal_no_wrap", 32'(pulse), 0);
        for (int i = 2; i < 5; i++) feed(8'(i));
        feed(0);
        chk("wrap7_wraps", 32'(wraps), 7);
        chk("wrap7_period", 32'(period), 6);
        feedw(1, 8'd7);
        rst = 1'b1;
        feed(2);
        chk("mid_rst_pwm", 32'(pwm), 0);
        chk("mid_rst_wraps", 32'(wraps), 0);
        chk("mid_rst_period", 32'(period), 0);
        chk("mid_rst_pvalid", 32'(pvalid), 0);
`ifdef MODN_WRAP_PWM_STICKY_IRQ_EN
        chk("mid_rst_irq", 32'(irq), 0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 5; i++) feed(8'(i));
        chk("post_rst_sync", 32'(pulse), 0);
        feed(0);
        chk("post_rst_pulse", 32'(pulse), 1);
        chk("post_rst_wraps", 32'(wraps), 1);
        chk("post_rst_pvalid", 32'(pvalid), 0);
        chk("post_rst_pwm_lost", 32'(pwm), 0);
`ifdef MODN_WRAP_PWM_STICKY_IRQ_EN
        chk("irq_set", 32'(irq), 1);
        irq_clr = 1'b1;
        feed(1);
        chk("irq_cleared", 32'(irq), 0);
        irq_clr = 1'b0;
        for (int i = 2; i < 5; i++) feed(8'(i));
        irq_clr = 1'b1;
        feed(0);
        chk("irq_set_wins", 32'(irq), 1);
        irq_clr = 1'b0;
`endif
        en   = 1'b0;
        s_en = 1'b1;
        for (int r = 0; r < 18; r++)
            for (int c = 0; c < 4; c++) sfeed(2'(c));
        chk("s_wraps_roll", 32'(s_wraps), 1);
        chk("s_period4", 32'(s_period), 4);
        chk("s_pvalid", 32'(s_pvalid), 1);
        sfeed(0);
        repeat (10) sfeed(1);
        sfeed(0);
        chk("s_period_sat", 32'(s_period), 7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
